rom_fetch: RTL and testbench
============================

Name: rom_fetch

Overview:
- Sequential fetch engine that sits directly upstream of the asynchronous program ROM.
- Drives the ROM Address, CS_bar and OE_bar, waits a fixed number of clocks to cover ROM access delay, then samples Data.
- Each byte is pushed with its address into a small output FIFO, which downstream logic (instruction register / decoder) drains with a valid/ready handshake.
- Supports sequential prefetch, redirect (jump) with flush, and a stall enable.

Parameters:
- AddressSize, 16, width of ROM address and program counter.
- WordSize, 8, width of ROM data word.
- WAIT_CYCLES, 3, clocks the strobes are held low before Data is sampled; must be >= 1. Covers 45 ns ROM delay at the system clock.
- FIFO_DEPTH, 2, output buffer entries; power of two, >= 2.
- RESET_ADDR, 0, program counter value after reset.

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- Address  output  AddressSize  ROM address, registered
- Data  input  WordSize  ROM data bus (read only; this block never drives it)
- CS_bar  output  1  ROM chip select, active low, registered
- OE_bar  output  1  ROM output enable, active low, registered
- enable  input  1  permits new fetches to start
- jump  input  1  redirect request, one-cycle pulse
- jump_addr  input  AddressSize  new fetch address when jump=1
- out_data  output  WordSize  FIFO head data
- out_addr  output  AddressSize  FIFO head address
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head this cycle
- busy  output  1  ROM access in progress (state ACCESS)

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, pc=RESET_ADDR, Address=RESET_ADDR, CS_bar=1, OE_bar=1.
  - FIFO count=0, FIFO storage=0, out_valid=0, out_data=0, out_addr=0, busy=0, wait counter=0.
  - Reset mid-access aborts the access with no FIFO write.
- States are IDLE and ACCESS.
- IDLE -> ACCESS:
  - Start condition at a clock edge: enable=1, jump=0, and FIFO count < FIFO_DEPTH. Count is sampled before any same-edge pop.
  - On that edge: Address<=pc, CS_bar<=0, OE_bar<=0, wait counter<=WAIT_CYCLES-1.
- ACCESS:
  - Strobes and Address are held stable.
  - The counter decrements each edge.
  - At the edge where counter==0 (the WAIT_CYCLES-th edge after the start edge):
    - Data is written to the FIFO tail together with Address.
    - pc<=pc+1, wrapping modulo 2^AddressSize (all-ones wraps to 0).
    - CS_bar<=1, OE_bar<=1, state<=IDLE.
- Turnaround:
  - At least one IDLE cycle with strobes high separates accesses.
  - Peak throughput is one word per WAIT_CYCLES+1 clocks.
- Latency: out_valid rises on the capture edge, WAIT_CYCLES edges after the start edge, when the FIFO was empty.
- Only one access is in flight at a time. Because start requires a free slot, the capture write can never overflow the FIFO.
- enable=0:
  - No new access starts.
  - An access already in ACCESS completes normally.
- jump=1 (highest priority, wins over capture, pop and start):
  - pc<=jump_addr, FIFO count<=0 so out_valid=0 after the edge.
  - Any in-flight access is aborted with no write: state<=IDLE, CS_bar<=1, OE_bar<=1.
  - The earliest fetch of jump_addr starts at the next edge.
- FIFO:
  - Pop occurs when out_valid && out_ready at an edge.
  - Push and pop on the same edge leave count unchanged and keep order.
  - out_data and out_addr always reflect the head entry. Their value is don't-care when empty, but they must not go X after reset.
- out_ready while out_valid=0 has no effect.
- busy = (state==ACCESS).

Test Plan:
- Reset release, ROM model with Mem[0..3]=11,22,33,44, WAIT_CYCLES=3, out_ready=1, enable=1 -> CS_bar/OE_bar low for exactly 3 cycles per access, high 1 cycle between. out_data sequence 11,22,33,44 with out_addr 0,1,2,3; one word every 4 clocks.
- out_ready=0 held -> exactly FIFO_DEPTH (2) words buffered, then CS_bar stays 1. Raise out_ready -> words pop in order and fetching resumes from address 2.
- Pulse jump with jump_addr=0x1234 during the second ACCESS cycle -> strobes high the next cycle, no FIFO write, out_valid=0. Next delivered word has out_addr=0x1234.
- pc preloaded via jump to 0xFFFF -> delivered addresses are 0xFFFF then 0x0000.
- Assert reset during ACCESS -> CS_bar=OE_bar=1 and out_valid=0 immediately without a clock. After release, fetching restarts at RESET_ADDR.
- enable dropped in mid-access -> the current word is still delivered, no further CS_bar assertion until enable returns.

Source files
------------

// File: rtl/rom_fetch.sv
// Fetch engine for an asynchronous program ROM: strobes the ROM, waits a fixed
// access time, then queues each byte with its address for the decoder.
module rom_fetch #(
    parameter int AddressSize = 16,
    parameter int WordSize = 8,
    parameter int WAIT_CYCLES = 3,
    parameter int FIFO_DEPTH = 2,
    parameter logic [AddressSize-1:0] RESET_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [AddressSize-1:0] Address,
    input  logic [WordSize-1:0]    Data,
    output logic                   CS_bar,
    output logic                   OE_bar,
    input  logic                   enable,
    input  logic                   jump,
    input  logic [AddressSize-1:0] jump_addr,
    output logic [WordSize-1:0]    out_data,
    output logic [AddressSize-1:0] out_addr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);

    logic [0:0]             state;
    logic [CW-1:0]          wait_cnt;
    logic [AddressSize-1:0] pc;

    logic [WordSize-1:0]    fifo_data [FIFO_DEPTH];
    logic [AddressSize-1:0] fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [PW:0]            count;

    logic start;
    logic capture;
    logic pop;

    // jump overrides every other action on the same edge
    always_comb begin
        start   = (state == IDLE) && enable && !jump && (count < DEPTH);
        capture = (state == ACCESS) && (wait_cnt == '0) && !jump;
        pop     = (count != '0) && out_ready && !jump;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_ADDR;
            Address  <= RESET_ADDR;
            CS_bar   <= 1'b1;
            OE_bar   <= 1'b1;
            wait_cnt <= '0;
        end else if (jump) begin
            state    <= IDLE;
            pc       <= jump_addr;
            CS_bar   <= 1'b1;
            OE_bar   <= 1'b1;
            wait_cnt <= '0;
        end else if (start) begin
            state    <= ACCESS;
            Address  <= pc;
            CS_bar   <= 1'b0;
            OE_bar   <= 1'b0;
            wait_cnt <= WAIT_LOAD;
        end else if (state == ACCESS) begin
            if (wait_cnt == '0) begin
                state  <= IDLE;
                pc     <= pc + AddressSize'(1);
                CS_bar <= 1'b1;
                OE_bar <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt - CW'(1);
            end
        end
    end

    // Start needs a free slot, so a capture never lands on a full FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_addr[i] <= '0;
            end
        end else if (jump) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (capture) begin
                fifo_data[wr_ptr] <= Data;
                fifo_addr[wr_ptr] <= Address;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (capture && !pop) begin
                count <= count + (PW+1)'(1);
            end else if (pop && !capture) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = fifo_data[rd_ptr];
    assign out_addr  = fifo_addr[rd_ptr];
    assign busy      = (state == ACCESS);

endmodule

// File: tb/tb_rom_fetch.sv
// Scoreboard bench for rom_fetch: an asynchronous ROM model feeds the DUT and
// every word popped from the output FIFO is checked against queued predictions.
module tb_rom_fetch;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int WC = 3;
    localparam int FD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] Address;
    logic [DW-1:0] Data;
    logic          CS_bar;
    logic          OE_bar;
    logic          enable;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    always #5 clk = ~clk;

    rom_fetch #(
        .AddressSize(AW),
        .WordSize(DW),
        .WAIT_CYCLES(WC),
        .FIFO_DEPTH(FD),
        .RESET_ADDR(16'h0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Address(Address),
        .Data(Data),
        .CS_bar(CS_bar),
        .OE_bar(OE_bar),
        .enable(enable),
        .jump(jump),
        .jump_addr(jump_addr),
        .out_data(out_data),
        .out_addr(out_addr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        case (a)
            16'h0000: rom_val = 8'h11;
            16'h0001: rom_val = 8'h22;
            16'h0002: rom_val = 8'h33;
            16'h0003: rom_val = 8'h44;
            default:  rom_val = a[7:0] ^ a[15:8] ^ 8'h5A;
        endcase
    endfunction

    always_comb Data = (!CS_bar && !OE_bar) ? rom_val(Address) : 8'h00;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_pop = -1;
    int   low_run = 0;
    int   oe_mismatch = 0;
    int   lows;
    bit   chk_rate = 0;
    bit   chk_strobe = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_seq(input logic [15:0] base, input int n);
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i);
            exp_q.push_back('{addr: a, data: rom_val(a)});
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic stop_popping();
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic reset_pulse(input logic en, input logic rdy);
        @(posedge clk);
        #1 reset = 1'b1;
        jump = 1'b0;
        exp_q.delete();
        enable = en;
        out_ready = rdy;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            low_run = 0;
            last_pop = -1;
        end else begin
            if (OE_bar !== CS_bar) oe_mismatch++;
            if (CS_bar == 1'b0) begin
                low_run++;
            end else begin
                if (low_run != 0 && chk_strobe) check_val("strobe_len", low_run, WC);
                low_run = 0;
            end
            if (out_valid && out_ready && !jump) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_empty", 0, 1);
                end else begin
                    exp_e = exp_q.pop_front();
                    check_val("pop_addr", out_addr, exp_e.addr);
                    check_val("pop_data", out_data, exp_e.data);
                end
                if (chk_rate && last_pop >= 0) check_val("pop_interval", cyc - last_pop, WC + 1);
                last_pop = cyc;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        jump = 1'b0;
        jump_addr = '0;
        out_ready = 1'b0;
        #12;
        check_val("rst_cs", CS_bar, 1);
        check_val("rst_oe", OE_bar, 1);
        check_val("rst_valid", out_valid, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_addr", Address, 16'h0000);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_addr", out_addr, 0);

        // Sequential fetch at peak rate
        enable = 1'b1;
        out_ready = 1'b1;
        chk_rate = 1;
        chk_strobe = 1;
        push_seq(16'h0000, 4);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("a_start_busy", busy, 1);
        check_val("a_start_cs", CS_bar, 0);
        check_val("a_start_addr", Address, 16'h0000);
        repeat (2) @(posedge clk);
        #1 check_val("a_not_yet_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check_val("a_valid_latency", out_valid, 1);
        check_val("a_cap_cs", CS_bar, 1);
        check_val("a_head_data", out_data, 8'h11);
        check_val("a_head_addr", out_addr, 16'h0000);
        wait_drain(40);
        stop_popping();
        chk_rate = 0;

        // Backpressure fills the FIFO and stalls fetching
        reset_pulse(1'b1, 1'b0);
        repeat (20) @(posedge clk);
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            if (!CS_bar) lows++;
        end
        check_val("b_full_no_fetch", lows, 0);
        check_val("b_full_valid", out_valid, 1);
        check_val("b_full_busy", busy, 0);
        check_val("b_head_addr", out_addr, 16'h0000);
        push_seq(16'h0000, 4);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain(60);
        stop_popping();

        // Jump during the second ACCESS cycle aborts the access
        chk_strobe = 0;
        reset_pulse(1'b1, 1'b1);
        @(posedge clk);
        #1 check_val("c_busy", busy, 1);
        @(posedge clk);
        #1;
        jump = 1'b1;
        jump_addr = 16'h1234;
        @(posedge clk);
        #1;
        jump = 1'b0;
        check_val("c_abort_cs", CS_bar, 1);
        check_val("c_abort_oe", OE_bar, 1);
        check_val("c_abort_valid", out_valid, 0);
        check_val("c_abort_busy", busy, 0);
        push_seq(16'h1234, 2);
        wait_drain(40);
        stop_popping();
        chk_strobe = 1;

        // Program counter wraps from all-ones to zero
        reset_pulse(1'b0, 1'b1);
        @(posedge clk);
        #1;
        jump = 1'b1;
        jump_addr = 16'hFFFF;
        @(posedge clk);
        #1;
        jump = 1'b0;
        enable = 1'b1;
        push_seq(16'hFFFF, 2);
        wait_drain(40);
        stop_popping();

        // Asynchronous reset in the middle of an access
        reset_pulse(1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #3;
        check_val("e_pre_busy", busy, 1);
        check_val("e_pre_valid", out_valid, 1);
        reset = 1'b1;
        #1;
        check_val("e_async_cs", CS_bar, 1);
        check_val("e_async_oe", OE_bar, 1);
        check_val("e_async_valid", out_valid, 0);
        check_val("e_async_busy", busy, 0);
        check_val("e_async_addr", Address, 16'h0000);
        exp_q.delete();
        push_seq(16'h0000, 2);
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        wait_drain(40);
        stop_popping();

        // enable dropped mid-access: current word completes, then fetching halts
        reset_pulse(1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1 enable = 1'b0;
        push_seq(16'h0000, 1);
        wait_drain(40);
        lows = 0;
        repeat (12) begin
            @(negedge clk);
            if (!CS_bar) lows++;
        end
        check_val("f_halt_no_fetch", lows, 0);
        check_val("f_halt_busy", busy, 0);
        #1 enable = 1'b1;
        push_seq(16'h0001, 2);
        wait_drain(40);
        stop_popping();

        check_val("oe_tracks_cs", oe_mismatch, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
